// File: rtl/lsb_mem_port_if.sv
// LSB request/response handshake plus the byte-wide RAM/IO bus owned by lsb_mem_port.
interface lsb_mem_port_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [6:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        idle;
    logic        resp_valid;
    logic [6:0]  resp_type;
    logic [31:0] resp_data;

    logic        bus_busy;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;

    // LSB and memory environment side
    modport master (
        output req_valid, req_op, req_type, req_addr, req_wdata, mem_din,
        input  idle, resp_valid, resp_type, resp_data, bus_busy, mem_a, mem_dout, mem_wr
    );

    // Memory port side
    modport slave (
        input  req_valid, req_op, req_type, req_addr, req_wdata, mem_din,
        output idle, resp_valid, resp_type, resp_data, bus_busy, mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/lsb_mem_port.sv
// Byte-serial load/store responder for the LSB: one request at a time on the 8-bit
// RAM/IO bus, one-cycle response with extended load data.
module lsb_mem_port #(
    parameter logic [6:0] LD_TYPE = 7'b0000011,
    parameter logic [6:0] S_TYPE  = 7'b0100011,
    parameter logic [1:0] IO_HI   = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            rob_clear,
    input  logic            io_buffer_full,
    lsb_mem_port_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [23:0] buf_q;
    logic [2:0]  k_q;
    logic        clr_q;

    logic        accept_c;
    logic        active_c;
    logic [2:0]  cur_op_c;
    logic [31:0] cur_addr_c;
    logic [31:0] cur_wdata_c;
    logic        cur_store_c;
    logic [2:0]  cur_k_c;
    logic [2:0]  n_c;
    logic        stall_c;
    logic [31:0] byte_addr_c;
    logic [7:0]  byte_data_c;
    logic [31:0] load_data_c;
    logic [1:0]  cap_idx_c;

    // k counts bus bytes issued; k==N is the trailing read-data cycle, k==N+1 completes.
    always_comb begin
        accept_c    = (state == IDLE) && bus.req_valid && !rob_clear &&
                      ((bus.req_type == LD_TYPE) || (bus.req_type == S_TYPE));
        active_c    = accept_c || (state != IDLE);
        cur_op_c    = accept_c ? bus.req_op    : op_q;
        cur_addr_c  = accept_c ? bus.req_addr  : addr_q;
        cur_wdata_c = accept_c ? bus.req_wdata : wdata_q;
        cur_store_c = accept_c ? (bus.req_type == S_TYPE) : (state == STORE);
        cur_k_c     = accept_c ? 3'd0 : k_q;

        case (cur_op_c[1:0])
            2'b00:   n_c = 3'd1;
            2'b01:   n_c = 3'd2;
            default: n_c = 3'd4;
        endcase

        stall_c     = cur_store_c && (cur_addr_c[17:16] == IO_HI) && io_buffer_full;
        byte_addr_c = cur_addr_c + 32'(cur_k_c);
        byte_data_c = cur_wdata_c[{cur_k_c[1:0], 3'b000} +: 8];
        cap_idx_c   = 2'(k_q - 3'd2);

        // Final byte arrives on mem_din in the completion cycle
        case (op_q[1:0])
            2'b00:   load_data_c = op_q[2] ? {24'd0, bus.mem_din}
                                           : {{24{bus.mem_din[7]}}, bus.mem_din};
            2'b01:   load_data_c = op_q[2] ? {16'd0, bus.mem_din, buf_q[7:0]}
                                           : {{16{bus.mem_din[7]}}, bus.mem_din, buf_q[7:0]};
            default: load_data_c = {bus.mem_din, buf_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= 3'd0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            buf_q          <= 24'd0;
            k_q            <= 3'd0;
            clr_q          <= 1'b0;
            bus.idle       <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_type  <= 7'd0;
            bus.resp_data  <= 32'd0;
            bus.bus_busy   <= 1'b0;
            bus.mem_a      <= 32'd0;
            bus.mem_dout   <= 8'd0;
            bus.mem_wr     <= 1'b0;
        end else if (rdy) begin
            bus.resp_valid <= 1'b0;
            if (rob_clear && (state != STORE)) begin
                // Flush: loads abort, and any same-edge request is dropped
                state         <= IDLE;
                k_q           <= 3'd0;
                clr_q         <= 1'b0;
                bus.idle      <= 1'b1;
                bus.resp_type <= 7'd0;
                bus.resp_data <= 32'd0;
                bus.bus_busy  <= 1'b0;
                bus.mem_a     <= 32'd0;
                bus.mem_dout  <= 8'd0;
                bus.mem_wr    <= 1'b0;
            end else begin
                if (accept_c) begin
                    op_q          <= bus.req_op;
                    addr_q        <= bus.req_addr;
                    wdata_q       <= bus.req_wdata;
                    clr_q         <= 1'b0;
                    bus.resp_type <= bus.req_type;
                    bus.idle      <= 1'b0;
                    state         <= (bus.req_type == S_TYPE) ? STORE : LOAD;
                end

                // A flushed store keeps writing but loses its response
                if (rob_clear) begin
                    clr_q <= 1'b1;
                end

                if (active_c) begin
                    if (cur_k_c < n_c) begin
                        if (stall_c) begin
                            bus.bus_busy <= 1'b0;
                            bus.mem_wr   <= 1'b0;
                            k_q          <= cur_k_c;
                        end else begin
                            bus.mem_a    <= byte_addr_c;
                            bus.mem_wr   <= cur_store_c;
                            bus.bus_busy <= 1'b1;
                            k_q          <= cur_k_c + 3'd1;
                            if (cur_store_c) begin
                                bus.mem_dout <= byte_data_c;
                            end
                        end
                    end else if (cur_k_c == n_c) begin
                        bus.bus_busy <= 1'b0;
                        bus.mem_wr   <= 1'b0;
                        k_q          <= n_c + 3'd1;
                    end else begin
                        state        <= IDLE;
                        k_q          <= 3'd0;
                        clr_q        <= 1'b0;
                        bus.idle     <= 1'b1;
                        bus.bus_busy <= 1'b0;
                        bus.mem_wr   <= 1'b0;
                        if (!(clr_q || rob_clear)) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_data  <= (state == LOAD) ? load_data_c : 32'd0;
                        end
                    end

                    // Byte k-2 is on mem_din while k is in 2..N
                    if ((state == LOAD) && (k_q >= 3'd2) && (k_q <= n_c)) begin
                        case (cap_idx_c)
                            2'd0:    buf_q[7:0]   <= bus.mem_din;
                            2'd1:    buf_q[15:8]  <= bus.mem_din;
                            default: buf_q[23:16] <= bus.mem_din;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lsb_mem_port.sv
// Directed bench for lsb_mem_port with a one-cycle-latency byte RAM model.
module tb_lsb_mem_port;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rob_clear;
    logic io_buffer_full;

    lsb_mem_port_if bus();

    lsb_mem_port dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rob_clear      (rob_clear),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Byte RAM: read data one cycle after address, frozen with rdy like the rest of the core
    logic [7:0]  ram [0:65535];
    logic [31:0] wlog_a [0:63];
    logic [7:0]  wlog_d [0:63];
    int          wcnt = 0;
    logic        pre_we = 1'b0;
    logic [15:0] pre_a = 16'd0;
    logic [7:0]  pre_d = 8'd0;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_a] <= pre_d;
        end else if (rdy && bus.mem_wr) begin
            ram[bus.mem_a[15:0]] <= bus.mem_dout;
            wlog_a[wcnt % 64]    <= bus.mem_a;
            wlog_d[wcnt % 64]    <= bus.mem_dout;
            wcnt                 <= wcnt + 1;
        end
        if (rdy) begin
            bus.mem_din <= ram[bus.mem_a[15:0]];
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pre_a  = a[15:0];
        pre_d  = d;
        pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    // Drive a one-cycle request; on return we are in cycle 0 after the accept edge
    task automatic do_req(input logic [2:0] op, input logic [6:0] typ,
                          input logic [31:0] a, input logic [31:0] wd);
        bus.req_op    = op;
        bus.req_type  = typ;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_resp(input string tag, input int budget);
        while (bus.resp_valid !== 1'b1 && cyc < budget) tick();
        check(tag, 32'(bus.resp_valid), 32'd1);
    endtask

    // Simple load: returns latency and data checks
    task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input int lat, input logic [31:0] exp);
        do_req(op, LD, a, 32'd0);
        wait_resp({tag, "_resp"}, 20);
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_data"}, bus.resp_data, exp);
    endtask

    int w0;
    int seen;

    initial begin
        rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_type = 7'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_idle",  32'(bus.idle), 32'd1);
        check("rst_resp",  32'(bus.resp_valid), 32'd0);
        check("rst_busy",  32'(bus.bus_busy), 32'd0);
        check("rst_wr",    32'(bus.mem_wr), 32'd0);
        check("rst_mem_a", bus.mem_a, 32'd0);
        check("rst_data",  bus.resp_data, 32'd0);

        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        poke(32'h200, 8'h80); poke(32'h202, 8'h01); poke(32'h203, 8'h80);
        poke(32'h300, 8'h11); poke(32'h301, 8'h22); poke(32'h302, 8'h33); poke(32'h303, 8'h44);
        poke(32'h30001, 8'h7F);

        // LW byte sequencing on the bus
        do_req(3'b010, LD, 32'h100, 32'd0);
        check("lw_busy0", 32'(bus.bus_busy), 32'd1);
        check("lw_wr0",   32'(bus.mem_wr), 32'd0);
        check("lw_idle0", 32'(bus.idle), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lw_a%0d", i), bus.mem_a, 32'h100 + 32'(i));
            tick();
        end
        wait_resp("lw_resp", 20);
        check("lw_lat",  32'(cyc), 32'd5);
        check("lw_data", bus.resp_data, 32'h12345678);
        check("lw_type", 32'(bus.resp_type), 32'(LD));
        check("lw_idle", 32'(bus.idle), 32'd1);
        tick();
        check("lw_pulse", 32'(bus.resp_valid), 32'd0);

        // Extension variants
        load_chk("lb",  3'b000, 32'h200, 2, 32'hFFFFFF80);
        load_chk("lbu", 3'b100, 32'h200, 2, 32'h00000080);
        load_chk("lh",  3'b001, 32'h202, 3, 32'hFFFF8001);
        load_chk("lhu", 3'b101, 32'h202, 3, 32'h00008001);

        // SH writes two bytes only
        w0 = wcnt;
        do_req(3'b001, ST, 32'h300, 32'hAABBCCDD);
        check("sh_wr0",  32'(bus.mem_wr), 32'd1);
        check("sh_dout0", 32'(bus.mem_dout), 32'hDD);
        wait_resp("sh_resp", 20);
        check("sh_lat",   32'(cyc), 32'd3);
        check("sh_data",  bus.resp_data, 32'd0);
        check("sh_type",  32'(bus.resp_type), 32'(ST));
        check("sh_nwr",   32'(wcnt - w0), 32'd2);
        check("sh_a0",    wlog_a[w0 % 64], 32'h300);
        check("sh_d0",    32'(wlog_d[w0 % 64]), 32'hDD);
        check("sh_a1",    wlog_a[(w0 + 1) % 64], 32'h301);
        check("sh_d1",    32'(wlog_d[(w0 + 1) % 64]), 32'hCC);
        tick();
        load_chk("sh_rd", 3'b010, 32'h300, 5, 32'h4433CCDD);

        // IO store stalls while the UART buffer is full
        w0 = wcnt;
        io_buffer_full = 1'b1;
        do_req(3'b000, ST, 32'h30000, 32'h0000005A);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("io_stall%0d", i), 32'(bus.mem_wr), 32'd0);
            if (i == 2) io_buffer_full = 1'b0;
            tick();
        end
        check("io_wr",   32'(bus.mem_wr), 32'd1);
        check("io_a",    bus.mem_a, 32'h30000);
        check("io_dout", 32'(bus.mem_dout), 32'h5A);
        wait_resp("io_resp", 20);
        check("io_lat", 32'(cyc), 32'd5);
        check("io_nwr", 32'(wcnt - w0), 32'd1);

        // IO loads ignore buffer-full
        io_buffer_full = 1'b1;
        load_chk("io_ld", 3'b100, 32'h30001, 2, 32'h0000007F);
        io_buffer_full = 1'b0;
        tick();

        // Flush aborts a load
        do_req(3'b010, LD, 32'h100, 32'd0);
        tick(); tick();
        rob_clear = 1'b1;
        tick();
        rob_clear = 1'b0;
        check("lwclr_idle", 32'(bus.idle), 32'd1);
        check("lwclr_busy", 32'(bus.bus_busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.resp_valid === 1'b1) seen++;
            tick();
        end
        check("lwclr_noresp", 32'(seen), 32'd0);

        // Flush lets a store finish silently
        w0 = wcnt;
        do_req(3'b010, ST, 32'h400, 32'hDEADBEEF);
        tick(); tick();
        rob_clear = 1'b1;
        tick();
        rob_clear = 1'b0;
        check("swclr_idle", 32'(bus.idle), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.resp_valid === 1'b1) seen++;
            tick();
        end
        check("swclr_noresp", 32'(seen), 32'd0);
        check("swclr_nwr",    32'(wcnt - w0), 32'd4);
        check("swclr_idle2",  32'(bus.idle), 32'd1);
        load_chk("swclr_rd", 3'b010, 32'h400, 5, 32'hDEADBEEF);

        // Request on the flush edge is dropped
        rob_clear = 1'b1;
        do_req(3'b010, LD, 32'h100, 32'd0);
        rob_clear = 1'b0;
        check("clrreq_idle", 32'(bus.idle), 32'd1);
        check("clrreq_busy", 32'(bus.bus_busy), 32'd0);
        tick();

        // Back-to-back: second request issued in the response cycle
        load_chk("b2b_1", 3'b000, 32'h200, 2, 32'hFFFFFF80);
        load_chk("b2b_2", 3'b001, 32'h202, 3, 32'hFFFF8001);
        tick();

        // rdy low for two edges mid-load
        do_req(3'b010, LD, 32'h100, 32'd0);
        tick();
        rdy = 1'b0;
        tick(); tick();
        rdy = 1'b1;
        wait_resp("rdy_resp", 20);
        check("rdy_lat",  32'(cyc), 32'd7);
        check("rdy_data", bus.resp_data, 32'h12345678);
        tick();

        // Reset in the middle of a store
        do_req(3'b010, ST, 32'h500, 32'h01020304);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_idle", 32'(bus.idle), 32'd1);
        check("rstmid_wr",   32'(bus.mem_wr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
